// File: rtl/odd_parity_tx.sv
// rtl/odd_parity_tx.sv - framed odd-parity serial transmitter with parallel word/parity strobe
// Optional build macro: ODD_PARITY_TX_ERR_INJECT_EN (adds inject_err to force bad parity on one frame).
module odd_parity_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
  input  logic              inject_err,
`endif
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic [DATA_W-1:0] par_data,
  output logic              par_bit,
  output logic              par_valid
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] par_data_q, par_data_d;
  logic              par_bit_q, par_bit_d;
  logic              par_valid_q, par_valid_d;
  logic              flip_par;
  logic              cyc_last;

`ifdef ODD_PARITY_TX_ERR_INJECT_EN
  assign flip_par = inject_err;
`else
  assign flip_par = 1'b0;
`endif

  assign cyc_last = (cyc_q == CYC_LAST);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    par_data_d  = par_data_q;
    par_bit_d   = par_bit_q;
    par_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          par_data_d  = in_data;
          sh_d        = in_data;
          par_bit_d   = ~^in_data ^ flip_par;
          par_valid_d = 1'b1;
          cyc_d       = '0;
          bit_d       = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cyc_last) begin
          cyc_d = '0;
          sh_d  = sh_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_PARITY;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_STOP;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      par_data_q  <= '0;
      par_bit_q   <= 1'b1;
      par_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      par_data_q  <= par_data_d;
      par_bit_q   <= par_bit_d;
      par_valid_q <= par_valid_d;
    end
  end

  // Line level is decoded from state so an async reset returns it high at once.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = sh_q[0];
      S_PARITY: tx = par_bit_q;
      default:  tx = 1'b1;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign par_data  = par_data_q;
  assign par_bit   = par_bit_q;
  assign par_valid = par_valid_q;

endmodule

// File: tb/tb_odd_parity_tx.sv
// tb/tb_odd_parity_tx.sv - directed and random frame checks against a bit-list frame model
module tb_odd_parity_tx;
  localparam int DW  = 4;
  localparam int CPB = 4;
  localparam int FRAME_CYC = (DW + 3) * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          inject_err = 1'b0;
  logic          in_ready, tx, busy, par_bit, par_valid;
  logic [DW-1:0] par_data;

  int n_cmp = 0;
  int n_bad = 0;

  odd_parity_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .in_ready(in_ready),
    .tx(tx),
    .busy(busy),
    .par_data(par_data),
    .par_bit(par_bit),
    .par_valid(par_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parity from a population count: an even number of ones needs a 1 to make the total odd.
  function automatic logic ref_par(input logic [DW-1:0] d, input logic inj);
    int ones = $countones(d);
    return ((ones % 2) == 0) ? ~inj : inj;
  endfunction

  function automatic logic ref_line(input logic [DW-1:0] d, input logic inj, input int k);
    int slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return d[slot-1];
    if (slot == DW + 1) return ref_par(d, inj);
    return 1'b1;
  endfunction

  // Called just after the transfer edge; checks every frame cycle and the idle cycle after it.
  task automatic check_frame(input logic [DW-1:0] d, input logic inj, input string nm);
    int pv_count = 0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      chk({nm, " tx"}, 32'(tx), 32'(ref_line(d, inj, k)));
      chk({nm, " busy"}, 32'(busy), 32'd1);
      chk({nm, " in_ready"}, 32'(in_ready), 32'd0);
      if (par_valid) pv_count++;
      if (k == 0) begin
        chk({nm, " par_valid_first"}, 32'(par_valid), 32'd1);
        chk({nm, " par_data"}, 32'(par_data), 32'(d));
        chk({nm, " par_bit"}, 32'(par_bit), 32'(ref_par(d, inj)));
      end
    end
    chk({nm, " par_valid_count"}, 32'(pv_count), 32'd1);
    chk({nm, " par_data_hold"}, 32'(par_data), 32'(d));
    @(negedge clk);
    chk({nm, " idle_tx"}, 32'(tx), 32'd1);
    chk({nm, " idle_busy"}, 32'(busy), 32'd0);
    chk({nm, " idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic launch(input logic [DW-1:0] d, input logic inj, input string nm);
    @(negedge clk);
    chk({nm, " ready_before"}, 32'(in_ready), 32'd1);
    in_data = d;
    in_valid = 1'b1;
    inject_err = inj;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inject_err = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst par_valid", 32'(par_valid), 32'd0);
    chk("rst par_bit", 32'(par_bit), 32'd1);
    chk("rst par_data", 32'(par_data), 32'd0);

    launch(4'b0000, 1'b0, "f0000");
    check_frame(4'b0000, 1'b0, "f0000");

    // 4'hF held valid throughout the 1011 frame must only be taken once the line is idle.
    launch(4'b1011, 1'b0, "f1011");
    in_data = 4'hF;
    in_valid = 1'b1;
    check_frame(4'b1011, 1'b0, "f1011");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_frame(4'hF, 1'b0, "fhold");

    // Reset during the third data bit; 4'b1010 puts a 0 on the line there.
    launch(4'b1010, 1'b0, "fabort");
    repeat (3 * CPB + 1) @(negedge clk);
    chk("abort tx_pre", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort tx", 32'(tx), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort par_valid", 32'(par_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_data = 4'b0110;
    in_valid = 1'b1;
    #1;
    chk("after_rst ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_frame(4'b0110, 1'b0, "fpost");

`ifdef ODD_PARITY_TX_ERR_INJECT_EN
    launch(4'b0000, 1'b1, "finj");
    check_frame(4'b0000, 1'b1, "finj");
    launch(4'b0000, 1'b0, "fclean");
    check_frame(4'b0000, 1'b0, "fclean");
`endif

    for (int i = 0; i < 8; i++) begin
      rd = DW'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      launch(rd, 1'b0, "frand");
      check_frame(rd, 1'b0, "frand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/odd_parity_tx.md
Name: odd_parity_tx

Overview:
- Upstream source for the odd-parity checker.
- Accepts a DATA_W-bit word on a valid/ready handshake and computes its odd parity bit.
- Serialises the word as a framed bit stream: start, data LSB-first, parity, stop.
- Also presents the parallel word plus parity for one cycle, so the checker can be driven directly or from the serial line.

Parameters:
- DATA_W, 4, data bits per frame; legal range 1..16.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- par_data  output  DATA_W  latched word of the current frame.
- par_bit  output  1  odd parity bit of the current frame.
- par_valid  output  1  one-cycle strobe: par_data/par_bit are new.

Behaviour:
- Reset (async assert, sync release on clk):
  - State IDLE; tx=1, in_ready=1, busy=0, par_valid=0.
  - par_data=0, par_bit=1 (odd parity of all-zero).
  - Bit and cycle counters cleared.
- Parity: par_bit = ~^word, so ones(word)+par_bit is always odd.
- Handshake:
  - in_ready = (state==IDLE).
  - Transfer occurs on a rising edge where in_valid && in_ready.
  - in_data is sampled only then; in_valid while busy is ignored and has no side effects.
- States and transitions:
  - IDLE: tx=1. On transfer, latch word and parity, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=word[i], i=0..DATA_W-1, each held CLKS_PER_BIT cycles; after bit DATA_W-1, go to PARITY.
  - PARITY: tx=par_bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - Transfer on edge N: tx falls after edge N; par_valid=1 for exactly the cycle after edge N; busy=1 from then on.
  - busy is high for exactly (DATA_W+3)*CLKS_PER_BIT cycles.
  - in_ready returns to 1 in the cycle after the last STOP cycle.
  - Back-to-back frames: the line stays high for at least one extra cycle beyond the stop bit.
- par_data/par_bit hold their values until the next transfer.
- Counters:
  - cycle counter width clog2(CLKS_PER_BIT+1); bit index width clog2(DATA_W+1).
  - No wrap-around is reachable within legal parameter ranges.
- Reset mid-frame:
  - tx forced to 1 immediately (asynchronous); frame discarded; no par_valid.
  - Next transfer is possible in the first cycle after rst_n deasserts.
- CLKS_PER_BIT=1: one bit per cycle; all rules above still hold.

Optional Feature:
- Macro: ODD_PARITY_TX_ERR_INJECT_EN.
- Defined:
  - Adds input port inject_err (1 bit), sampled together with in_data at transfer.
  - If inject_err=1, the transmitted and presented parity bit is inverted (par_bit = ^word) for that frame only.
  - Used to exercise checker error detection.
- Not defined: port absent; parity is always correct.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> tx=1, in_ready=1, busy=0, par_valid=0, par_bit=1.
- Send 4'b0000 (CLKS_PER_BIT=4):
  - tx sequence 0,0,0,0,0,1,1, each level held 4 cycles.
  - par_valid pulses once with par_data=0, par_bit=1.
  - busy high 28 cycles; in_ready low 28 cycles.
- Send 4'b1011 -> data bits on tx are 1,1,0,1 (LSB first); par_bit=0; frame 28 cycles.
- Hold in_valid=1 with in_data=4'hF during an active frame:
  - no second par_valid until in_ready returns.
  - 4'hF is then accepted with par_bit=1.
- Assert rst_n=0 during the third DATA bit:
  - tx=1 within the same cycle; busy=0.
  - A new word sent after release produces a complete, correct frame.
- With ODD_PARITY_TX_ERR_INJECT_EN: send 4'b0000 with inject_err=1 -> par_bit=0 and tx parity slot=0; the next frame without inject_err is correct.
